// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing helpers and default flag margins for the
// peripheral-path FIFOs (UART RX/TX buffering, keyboard queue).
//   depth_of(aw)    -> number of entries for an address width
//   count_width(aw) -> bits needed to hold an occupancy of 0..DEPTH
//   AFULL_MARGIN    -> almost_full rises this many entries below full
//   AEMPTY_MARGIN   -> almost_empty holds while count <= this value
package fifo_pkg;

    localparam int AFULL_MARGIN  = 4;
    localparam int AEMPTY_MARGIN = 4;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    // One extra bit so a completely full FIFO is distinguishable from empty.
    function automatic int count_width(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: WIDTH x DEPTH simple dual-port storage for fifo_stat.
//   clk   - write clock
//   we    - write enable, writes din into mem[waddr] at posedge
//   waddr - write address
//   din   - write data
//   raddr - read address (asynchronous read)
//   q     - read data, mem[raddr]
// Contents are deliberately not reset.
module fifo_ram #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 7
)(
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      din,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      q
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= din;
        end
    end

    assign q = mem[raddr];

endmodule

// File: rtl/fifo_stat.sv
// fifo_stat: single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty flags, sticky overflow/underflow flags and a
// selectable first-word-fall-through or registered read port.
//   clk, reset      - clock and asynchronous active-high reset
//   wr, din         - write request and data
//   rd              - read/pop request
//   dout            - read data (head word when FWFT=1, registered when FWFT=0)
//   empty, full     - occupancy 0 / DEPTH
//   almost_empty    - count <= AEMPTY_LEVEL
//   almost_full     - count >= AFULL_LEVEL
//   count           - occupancy 0..DEPTH
//   overflow        - sticky, write attempted while full and not freed
//   underflow       - sticky, read attempted while empty
//   clr_err         - synchronous clear of overflow/underflow
//   raddr, waddr    - pointer debug monitors
module fifo_stat
    import fifo_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int ADDR_WIDTH   = 7,
    parameter int FWFT         = 1,
    parameter int AFULL_LEVEL  = depth_of(ADDR_WIDTH) - AFULL_MARGIN,
    parameter int AEMPTY_LEVEL = AEMPTY_MARGIN
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [WIDTH-1:0]      din,
    input  logic                  rd,
    output logic [WIDTH-1:0]      dout,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [ADDR_WIDTH-1:0] waddr
);

    localparam int CW = count_width(ADDR_WIDTH);
    localparam logic [CW-1:0] DEPTH_CNT  = CW'(depth_of(ADDR_WIDTH));
    localparam logic [CW-1:0] AFULL_CNT  = CW'(AFULL_LEVEL);
    localparam logic [CW-1:0] AEMPTY_CNT = CW'(AEMPTY_LEVEL);

    logic             rd_ok;
    logic             wr_ok;
    logic [WIDTH-1:0] rd_data;

    // Flags come straight from registered count so they settle right after the edge.
    assign empty        = (count == '0);
    assign full         = (count == DEPTH_CNT);
    assign almost_empty = (count <= AEMPTY_CNT);
    assign almost_full  = (count >= AFULL_CNT);

    // A full FIFO may take a write only when the same edge frees a slot;
    // an empty FIFO never bypasses a simultaneous write to the reader.
    assign rd_ok = rd & ~empty;
    assign wr_ok = wr & (~full | rd_ok);

    fifo_ram #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (waddr),
        .din   (din),
        .raddr (raddr),
        .q     (rd_data)
    );

    // Pointers wrap naturally at DEPTH because they are exactly ADDR_WIDTH bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            waddr <= '0;
            raddr <= '0;
        end else begin
            if (wr_ok) begin
                waddr <= waddr + 1'b1;
            end
            if (rd_ok) begin
                raddr <= raddr + 1'b1;
            end
        end
    end

    // Simultaneous accepted read and write leaves occupancy unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a set in the same cycle as clr_err takes priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (wr & full & ~rd_ok) | (overflow & ~clr_err);
            underflow <= (rd & empty) | (underflow & ~clr_err);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown directly; an empty FIFO presents zero.
            assign dout = empty ? '0 : rd_data;
        end else begin : g_reg
            logic [WIDTH-1:0] dout_q;

            // Loads the pre-increment head on an accepted read, holds otherwise.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    dout_q <= '0;
                end else if (rd_ok) begin
                    dout_q <= rd_data;
                end
            end

            assign dout = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_stat.sv
// tb_fifo_stat: drives a FWFT=1 and a FWFT=0 instance of fifo_stat
// (DEPTH 4, AFULL_LEVEL 3, AEMPTY_LEVEL 1) with identical stimulus and
// compares every output against a queue-based reference model.
module tb_fifo_stat;

    localparam int W  = 8;
    localparam int AW = 2;
    localparam int D  = 4;
    localparam int AF = 3;
    localparam int AE = 1;

    logic          clk;
    logic          reset;
    logic          wr;
    logic [W-1:0]  din;
    logic          rd;
    logic          clr_err;

    logic [W-1:0]  dout_a,   dout_b;
    logic          empty_a,  empty_b;
    logic          full_a,   full_b;
    logic          aempty_a, aempty_b;
    logic          afull_a,  afull_b;
    logic [AW:0]   count_a,  count_b;
    logic          ovf_a,    ovf_b;
    logic          udf_a,    udf_b;
    logic [AW-1:0] raddr_a,  raddr_b;
    logic [AW-1:0] waddr_a,  waddr_b;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int ref_q[$];
    int m_ovf, m_udf, m_reg_dout, m_pushes, m_pops;

    fifo_stat #(
        .WIDTH(W), .ADDR_WIDTH(AW), .FWFT(1), .AFULL_LEVEL(AF), .AEMPTY_LEVEL(AE)
    ) dut_a (
        .clk(clk), .reset(reset), .wr(wr), .din(din), .rd(rd), .dout(dout_a),
        .empty(empty_a), .full(full_a), .almost_empty(aempty_a), .almost_full(afull_a),
        .count(count_a), .overflow(ovf_a), .underflow(udf_a), .clr_err(clr_err),
        .raddr(raddr_a), .waddr(waddr_a)
    );

    fifo_stat #(
        .WIDTH(W), .ADDR_WIDTH(AW), .FWFT(0), .AFULL_LEVEL(AF), .AEMPTY_LEVEL(AE)
    ) dut_b (
        .clk(clk), .reset(reset), .wr(wr), .din(din), .rd(rd), .dout(dout_b),
        .empty(empty_b), .full(full_b), .almost_empty(aempty_b), .almost_full(afull_b),
        .count(count_b), .overflow(ovf_b), .underflow(udf_b), .clr_err(clr_err),
        .raddr(raddr_b), .waddr(waddr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ref_q.delete();
        m_ovf = 0; m_udf = 0; m_reg_dout = 0; m_pushes = 0; m_pops = 0;
    endtask

    // One clock of stimulus; the model applies the accept rules to its own queue.
    task automatic applyStimulus(input bit w, input int d, input bit r, input bit c);
        bit was_full, was_empty, r_ok, w_ok;
        wr = w; din = W'(d); rd = r; clr_err = c;
        was_full  = (ref_q.size() == D);
        was_empty = (ref_q.size() == 0);
        r_ok = r && !was_empty;
        w_ok = w && (!was_full || r_ok);
        @(posedge clk);
        m_ovf = int'((w && was_full && !r_ok) || (m_ovf != 0 && !c));
        m_udf = int'((r && was_empty) || (m_udf != 0 && !c));
        if (r_ok) begin
            m_reg_dout = ref_q.pop_front();
            m_pops++;
        end
        if (w_ok) begin
            ref_q.push_back(d & 8'hFF);
            m_pushes++;
        end
        #1;
        wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        int n;
        n = ref_q.size();
        compare({tag, ":count"},   32'(count_a),  32'(n));
        compare({tag, ":empty"},   32'(empty_a),  32'(n == 0));
        compare({tag, ":full"},    32'(full_a),   32'(n == D));
        compare({tag, ":aempty"},  32'(aempty_a), 32'(n <= AE));
        compare({tag, ":afull"},   32'(afull_a),  32'(n >= AF));
        compare({tag, ":ovf"},     32'(ovf_a),    32'(m_ovf));
        compare({tag, ":udf"},     32'(udf_a),    32'(m_udf));
        compare({tag, ":waddr"},   32'(waddr_a),  32'(m_pushes % D));
        compare({tag, ":raddr"},   32'(raddr_a),  32'(m_pops % D));
        compare({tag, ":dout_ft"}, 32'(dout_a),   (n == 0) ? 32'd0 : 32'(ref_q[0]));
        compare({tag, ":dout_rg"}, 32'(dout_b),   32'(m_reg_dout));
        compare({tag, ":count_b"}, 32'(count_b),  32'(n));
        compare({tag, ":flags_b"}, 32'({empty_b, full_b, aempty_b, afull_b, ovf_b, udf_b}),
                                   32'({empty_a, full_a, aempty_a, afull_a, ovf_a, udf_a}));
        compare({tag, ":ptrs_b"},  32'({raddr_b, waddr_b}), 32'({raddr_a, waddr_a}));
    endtask

    task automatic sync_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        int vals[4];
        wr = 1'b0; rd = 1'b0; din = '0; clr_err = 1'b0;
        reset = 1'b1;
        model_reset();
        #12;
        checkOutput("reset");
        reset = 1'b0;
        @(negedge clk);

        // Fill: flags walk through almost_empty/almost_full/full, head stays 0x11.
        vals = '{32'h11, 32'h22, 32'h33, 32'h44};
        foreach (vals[i]) begin
            applyStimulus(1'b1, vals[i], 1'b0, 1'b0);
            checkOutput($sformatf("fill%0d", i));
        end
        compare("fill_dout_const", 32'(dout_a), 32'h11);

        // Overflow, then a write accepted against a simultaneous read when full.
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
        checkOutput("ovf");
        compare("ovf_const", 32'({ovf_a, count_a}), 32'({1'b1, 3'd4}));
        applyStimulus(1'b1, 8'h66, 1'b1, 1'b0);
        checkOutput("full_rw");
        compare("full_rw_dout_const", 32'(dout_a), 32'h22);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 0, 1'b1, 1'b0);
            checkOutput($sformatf("drain%0d", i));
        end
        compare("drain_rg_const", 32'(dout_b), 32'h66);

        // Read on empty with a simultaneous write: no bypass, underflow set.
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
        checkOutput("udf_rw");
        compare("udf_rw_const", 32'({udf_a, count_a, dout_a}), 32'({1'b1, 3'd1, 8'h77}));
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkOutput("pop77");
        applyStimulus(1'b0, 0, 1'b1, 1'b1);
        checkOutput("clr_vs_set");
        compare("clr_vs_set_const", 32'(udf_a), 32'd1);
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
        checkOutput("clr_only");
        compare("clr_only_const", 32'({ovf_a, udf_a}), 32'd0);

        // Registered read port: A1 then B2, then hold on an empty read.
        sync_reset();
        checkOutput("reset2");
        applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hB2, 1'b0, 1'b0);
        checkOutput("rg_fill");
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        compare("rg_first_const", 32'(dout_b), 32'hA1);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        compare("rg_second_const", 32'(dout_b), 32'hB2);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkOutput("rg_hold");
        compare("rg_hold_const", 32'(dout_b), 32'hB2);

        // Asynchronous reset between edges clears state with no clock edge.
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h02, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h03, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h04, 1'b0, 1'b0);
        checkOutput("pre_async");
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checkOutput("async_reset");
        compare("async_const", 32'({count_a, empty_a, raddr_a, waddr_a, ovf_a, udf_a, dout_b}),
                32'({3'd0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 8'h00}));
        #1;
        reset = 1'b0;
        @(negedge clk);

        // Randomized traffic against the model, with occasional error clears.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom % 100) < 55, int'($urandom_range(0, 255)),
                          ($urandom % 100) < 50, ($urandom % 100) < 10);
            checkOutput($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
